// File: rtl/bin_to_bcd_formatter.sv
// Sequential double-dabble converter: 32-bit unsigned/signed operand to 8 packed BCD digits,
// with a one-cycle load pulse for the downstream seven-segment display driver.
module bin_to_bcd_formatter #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        is_signed,
  output logic        busy,
  output logic [31:0] bcd_out,
  output logic        load,
  output logic        negative,
  output logic        overflow
);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] bcd_q, bcd_d;
  logic        load_q, load_d;
  logic        negative_q, negative_d;
  logic        overflow_q, overflow_d;

  logic [39:0] acc_adj;
  logic        acc_ovf;

  // Add-3 correction on every nibble >= 5 so each digit stays 0..9 after the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 10; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign acc_ovf = |acc_q[39:32];

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_r_d    = neg_r_q;
    bcd_d      = bcd_q;
    load_d     = 1'b0;
    negative_d = negative_q;
    overflow_d = overflow_q;

    case (state_q)
      StIdle: begin
        // The load cycle is still the tail of the previous conversion: start is ignored there.
        if (start && !load_q) begin
          if (is_signed && value[31]) begin
            mag_d   = ~value + 32'd1;
            neg_r_d = 1'b1;
          end else begin
            mag_d   = value;
            neg_r_d = 1'b0;
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d = {acc_adj[38:0], mag_q[31]};
        mag_d = {mag_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        overflow_d = acc_ovf;
        negative_d = neg_r_q;
        bcd_d      = (acc_ovf && SATURATE) ? 32'h9999_9999 : acc_q[31:0];
        load_d     = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_r_q    <= 1'b0;
      bcd_q      <= '0;
      load_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_r_q    <= neg_r_d;
      bcd_q      <= bcd_d;
      load_q     <= load_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign bcd_out  = bcd_q;
  assign load     = load_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_formatter.sv
// Scoreboard bench for bin_to_bcd_formatter: saturating and truncating instances share stimulus;
// a negedge monitor pops expected results on every load pulse.
module tb_bin_to_bcd_formatter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic        is_signed;

  logic        busy_s, load_s, neg_s, ovf_s;
  logic [31:0] bcd_s;
  logic        busy_t, load_t, neg_t, ovf_t;
  logic [31:0] bcd_t;

  typedef struct {
    logic [31:0] bcd_sat;
    logic [31:0] bcd_trn;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  bin_to_bcd_formatter #(.SATURATE(1'b1)) u_dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .is_signed(is_signed),
    .busy     (busy_s),
    .bcd_out  (bcd_s),
    .load     (load_s),
    .negative (neg_s),
    .overflow (ovf_s)
  );

  bin_to_bcd_formatter #(.SATURATE(1'b0)) u_dut_trn (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .is_signed(is_signed),
    .busy     (busy_t),
    .bcd_out  (bcd_t),
    .load     (load_t),
    .negative (neg_t),
    .overflow (ovf_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every load pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (load_s || load_t) begin
      chk("load_lockstep", {31'd0, load_t}, {31'd0, load_s});
      if (sb_q.size() == 0) begin
        chk("unexpected_load", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("bcd_sat", bcd_s, e.bcd_sat);
        chk("bcd_trn", bcd_t, e.bcd_trn);
        chk("negative", {31'd0, neg_s}, {31'd0, e.neg});
        chk("overflow", {31'd0, ovf_s}, {31'd0, e.ovf});
        chk("negative_trn", {31'd0, neg_t}, {31'd0, e.neg});
        chk("overflow_trn", {31'd0, ovf_t}, {31'd0, e.ovf});
      end
    end
  end

  task automatic convert(input logic [31:0] v, input logic s, input logic [31:0] e_sat,
                         input logic [31:0] e_trn, input logic n, input logic o,
                         input bit disturb);
    exp_t e;
    int   busy_cnt;
    int   lat;
    @(negedge clk);
    value     = v;
    is_signed = s;
    start     = 1'b1;
    e.bcd_sat = e_sat;
    e.bcd_trn = e_trn;
    e.neg     = n;
    e.ovf     = o;
    sb_q.push_back(e);
    @(posedge clk);
    busy_cnt = 0;
    lat      = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (disturb && i == 10) begin
        start     = 1'b1;
        value     = ~v;
        is_signed = ~s;
      end
      if (disturb && i == 11) start = 1'b0;
      if (disturb && i == 20) value = 32'h1234_5678;
      if (busy_s) busy_cnt++;
      if (load_s) lat = i;
    end
    if (lat == 0) begin
      chk("load_timeout", 32'd0, 32'd34);
    end else begin
      chk("latency", lat, 32'd34);
      chk("busy_cycles", busy_cnt, 32'd33);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    value     = '0;
    is_signed = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_s}, 32'd0);
    chk("rst_load", {31'd0, load_s}, 32'd0);
    chk("rst_bcd", bcd_s, 32'd0);
    chk("rst_neg", {31'd0, neg_s}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_s}, 32'd0);
    rst_n = 1'b1;

    //       value          sgn   sat bcd        trunc bcd      neg   ovf   disturb
    convert(32'd0,          1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    convert(32'd0,          1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    convert(32'h00BC_614E,  1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    convert(32'h05F5_E0FF,  1'b0, 32'h9999_9999, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
    convert(32'h05F5_E100,  1'b0, 32'h9999_9999, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    convert(32'hFFFF_FFFF,  1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    convert(32'hFFFF_FFFF,  1'b0, 32'h9999_9999, 32'h9496_7295, 1'b0, 1'b1, 1'b0);
    convert(32'hFF43_9EB2,  1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    convert(32'h0000_00FF,  1'b0, 32'h0000_0255, 32'h0000_0255, 1'b0, 1'b0, 1'b0);
    convert(32'h0000_0007,  1'b1, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    convert(32'h00BC_614E,  1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    convert(32'h8000_0000,  1'b1, 32'h9999_9999, 32'h4748_3648, 1'b1, 1'b1, 1'b0);

    // Reset during iteration 15: no load, everything cleared on the next edge.
    @(negedge clk);
    value     = 32'h00BC_614E;
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy_s}, 32'd0);
    chk("midrst_load", {31'd0, load_s}, 32'd0);
    chk("midrst_bcd", bcd_s, 32'd0);
    chk("midrst_neg", {31'd0, neg_s}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf_s}, 32'd0);
    chk("midrst_bcd_trn", bcd_t, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_bcd_hold", bcd_s, 32'd0);

    convert(32'd987_654_32, 1'b0, 32'h9876_5432, 32'h9876_5432, 1'b0, 1'b0, 1'b0);

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
